// File: rtl/kf_meas_source.sv
// kf_meas_source: periodic SPI ADC reader (mode 0, MSB first) that presents each sample as z/z_valid
// Ports: clk, rst (sync, active high), enable (run periodic sampling),
//        spi_sclk/spi_cs_n/spi_miso (ADC link), z/z_valid (sample + one-clk update strobe),
//        busy (transaction in progress), sample_cnt (completed samples, wraps)
module kf_meas_source #(
  parameter int CLK_DIV       = 4,
  parameter int DATA_BITS     = 16,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  input  logic                 spi_miso,
  output logic [DATA_BITS-1:0] z,
  output logic                 z_valid,
  output logic                 busy,
  output logic [15:0]          sample_cnt
);
  localparam int CMAX = CS_SETUP > CLK_DIV ? CS_SETUP : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(2 * DATA_BITS + 1);
  localparam int TW   = $clog2(SAMPLE_PERIOD + 1);

  if (SAMPLE_PERIOD < CS_SETUP + 2 * DATA_BITS * CLK_DIV + 4) begin : g_bad_period
    $error("SAMPLE_PERIOD too short for one SPI transaction");
  end

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [HW-1:0]        r_half;
  logic [TW-1:0]        r_timer;
  logic [DATA_BITS-1:0] r_shift, r_z;
  logic [15:0]          r_sample_cnt;
  logic                 r_sclk, r_cs_n, r_zv;
  logic                 w_start, w_setup_done, w_tick, w_last;

  always_comb begin
    w_start      = r_state == IDLE && enable && r_timer == '0;
    w_setup_done = r_cnt == CW'(CS_SETUP - 1);
    w_tick       = r_cnt == CW'(CLK_DIV - 1);
    // last tick of the final high half-period: the DATA_BITS-th falling edge
    w_last       = w_tick && r_half == HW'(2 * DATA_BITS - 1);
    w_next       = r_state == IDLE  ? (w_start ? SETUP : IDLE) :
                   r_state == SETUP ? (w_setup_done ? SHIFT : SETUP) :
                   r_state == SHIFT ? (w_last ? HOLD : SHIFT) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_half       <= '0;
      r_timer      <= '0;
      r_shift      <= '0;
      r_z          <= '0;
      r_sample_cnt <= '0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_zv         <= 1'b0;
    end else begin
      r_cs_n  <= w_next == IDLE;
      r_zv    <= r_state == HOLD;
      r_timer <= !enable ? '0 : w_start ? TW'(SAMPLE_PERIOD - 1) : r_timer != '0 ? r_timer - 1'b1 : r_timer;
      r_cnt   <= r_state == SETUP ? (w_setup_done ? '0 : r_cnt + 1'b1) :
                 r_state == SHIFT ? (w_tick ? '0 : r_cnt + 1'b1) : '0;
      r_half  <= r_state == SHIFT ? (w_tick ? r_half + 1'b1 : r_half) : '0;
      r_sclk  <= r_state == SHIFT ? (w_tick ? ~r_sclk : r_sclk) : 1'b0;
      // capture on the edge that raises sclk, so the ADC has had a full half-period to settle
      if (r_state == SHIFT && w_tick && !r_sclk) r_shift <= {r_shift[DATA_BITS-2:0], spi_miso};
      if (r_state == HOLD) begin
        r_z          <= r_shift;
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end
    end
  end

  assign spi_sclk   = r_sclk;
  assign spi_cs_n   = r_cs_n;
  assign z          = r_z;
  assign z_valid    = r_zv;
  assign busy       = r_state != IDLE;
  assign sample_cnt = r_sample_cnt;
endmodule

// File: tb/tb_kf_meas_source.sv
// tb_kf_meas_source: scoreboard bench for kf_meas_source with behavioural SPI ADC models
module tb_kf_meas_source;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, en6 = 1'b0;
  logic        miso, sclk, cs_n, zv, busy;
  logic [15:0] z, cnt;
  logic        miso6, sclk6, cs6, zv6, busy6;
  logic [15:0] z6, cnt6;

  always #5 clk = ~clk;

  kf_meas_source dut (
    .clk(clk), .rst(rst), .enable(enable), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_miso(miso),
    .z(z), .z_valid(zv), .busy(busy), .sample_cnt(cnt)
  );

  kf_meas_source #(.CLK_DIV(1), .DATA_BITS(16), .CS_SETUP(1), .SAMPLE_PERIOD(40)) dut6 (
    .clk(clk), .rst(rst), .enable(en6), .spi_sclk(sclk6), .spi_cs_n(cs6), .spi_miso(miso6),
    .z(z6), .z_valid(zv6), .busy(busy6), .sample_cnt(cnt6)
  );

  logic [15:0] adc_word = 16'h0, adc_sr = 16'h0, adc6_word = 16'h0, adc6_sr = 16'h0;
  assign miso  = adc_sr[15];
  assign miso6 = adc6_sr[15];
  always @(negedge cs_n) adc_sr = adc_word;
  always @(negedge sclk) if (!cs_n) adc_sr = adc_sr << 1;
  always @(negedge cs6) adc6_sr = adc6_word;
  always @(negedge sclk6) if (!cs6) adc6_sr = adc6_sr << 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [15:0] z; logic [15:0] cnt; int gap;} exp_t;
  exp_t q[$];
  exp_t e;

  task automatic push(logic [15:0] ez, logic [15:0] ec, int gap);
    exp_t t;
    t.z = ez; t.cnt = ec; t.gap = gap;
    q.push_back(t);
  endtask

  int cyc = 0, fall_cyc = 0, rises = 0, n_fall = 0, n_pop = 0, last_vcyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_zv = 1'b0;
  logic [15:0] last_z = 16'h0, prev_z = 16'h0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !cs_n) begin
      fall_cyc = cyc;
      rises = 0;
      n_fall++;
    end
    if (!prev_sclk && sclk) rises++;
    if (zv) begin
      chk("zv_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("z", z, e.z);
        chk("sample_cnt", cnt, e.cnt);
        chk("latency", cyc - fall_cyc, 131);
        chk("sclk_rises", rises, 16);
        chk("z_held", prev_z, last_z);
        chk("zv_single", prev_zv, 0);
        if (e.gap != 0) chk("zv_spacing", cyc - last_vcyc, e.gap);
      end
      last_z = z;
      last_vcyc = cyc;
      n_pop++;
    end
    if (rst) last_z = 16'h0;
    prev_z = z; prev_cs = cs_n; prev_sclk = sclk; prev_zv = zv;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sel_val(int s);
    return s == 0 ? n_pop : s == 1 ? n_fall : rises;
  endfunction

  task automatic wait_until(int s, int target, int budget, string name);
    int i = 0;
    while (sel_val(s) < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, sel_val(s) >= target, 1);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_cs_n"}, cs_n, 1);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_zv"}, zv, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, cnt, 0);
  endtask

  initial begin
    int f, lat, r6;
    logic ps;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f, lat, r6;
    logic ps;
    rst = 1'b1;
    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    tick(2);
    chk("disabled_no_start", cs_n, 1);
    // T1: first sample
    adc_word = 16'h1234;
    push(16'h1234, 16'd1, 0);
    enable = 1'b1;
    tick(1);
    chk("t1_cs_fall_1clk", cs_n, 0);
    chk("t1_busy", busy, 1);
    wait_until(0, 1, 300, "t1_pop_timeout");
    // T2: full-scale extremes, exact period spacing
    adc_word = 16'h8000;
    push(16'h8000, 16'd2, 1000);
    wait_until(0, 2, 1100, "t2a_pop_timeout");
    adc_word = 16'h7FFF;
    push(16'h7FFF, 16'd3, 1000);
    wait_until(0, 3, 1100, "t2b_pop_timeout");
    // T3: drop enable mid-transfer
    adc_word = 16'h0F0F;
    push(16'h0F0F, 16'd4, 1000);
    wait_until(1, 4, 1100, "t3_fall_timeout");
    wait_until(2, 5, 100, "t3_rise5_timeout");
    enable = 1'b0;
    wait_until(0, 4, 200, "t3_pop_timeout");
    f = n_fall;
    tick(1200);
    chk("t3_no_new_start", n_fall, f);
    chk("t3_idle_busy", busy, 0);
    adc_word = 16'hA5A5;
    push(16'hA5A5, 16'd5, 0);
    enable = 1'b1;
    tick(1);
    chk("t3_restart_1clk", cs_n, 0);
    wait_until(0, 5, 300, "t3b_pop_timeout");
    // T4: reset mid-transfer
    adc_word = 16'h5555;
    wait_until(1, 6, 1100, "t4_fall_timeout");
    wait_until(2, 8, 100, "t4_rise8_timeout");
    rst = 1'b1;
    tick(1);
    chk_reset("t4");
    adc_word = 16'h00FF;
    push(16'h00FF, 16'd1, 0);
    rst = 1'b0;
    tick(1);
    chk("t4_restart_1clk", cs_n, 0);
    wait_until(0, 6, 300, "t4_pop_timeout");
    // T5: sample counter wrap
    tick(5);
    force dut.r_sample_cnt = 16'hFFFF;
    tick(1);
    release dut.r_sample_cnt;
    tick(1);
    chk("t5_preload", cnt, 16'hFFFF);
    adc_word = 16'h3C3C;
    push(16'h3C3C, 16'd0, 1000);
    wait_until(0, 7, 1100, "t5_pop_timeout");
    enable = 1'b0;
    tick(200);
    // T6: fastest clocking
    adc6_word = 16'hC3A5;
    en6 = 1'b1;
    tick(1);
    chk("t6_cs_fall_1clk", cs6, 0);
    lat = 0;
    r6 = 0;
    ps = sclk6;
    while (!zv6 && lat < 100) begin
      tick(1);
      lat++;
      if (!ps && sclk6) r6++;
      ps = sclk6;
    end
    chk("t6_latency", lat, 34);
    chk("t6_z", z6, 16'hC3A5);
    chk("t6_rises", r6, 16);
    chk("t6_cnt", cnt6, 1);
    en6 = 1'b0;
    tick(5);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
